// File: rtl/fpu_pkg.sv
// Shared FP field geometry and NaN classification for the result buffer.
// Widths are derived from the operand width X (32 or 64).
package fpu_pkg;

    localparam int unsigned MAX_X = 64;

    function automatic int unsigned expo_bits(input int unsigned x);
        return (x == 64) ? 32'd11 : 32'd8;
    endfunction

    function automatic int unsigned mant_bits(input int unsigned x);
        return (x == 64) ? 32'd52 : 32'd23;
    endfunction

    function automatic int unsigned bias(input int unsigned x);
        return (x == 64) ? 32'd1023 : 32'd127;
    endfunction

    // Word is zero-extended to MAX_X; exponent all ones with nonzero mantissa.
    function automatic logic is_nan(input logic [MAX_X-1:0] word, input int unsigned x);
        logic [MAX_X-1:0] mant_mask;
        logic [MAX_X-1:0] expo_mask;
        logic [MAX_X-1:0] expo_field;
        mant_mask  = (MAX_X'(1) << mant_bits(x)) - MAX_X'(1);
        expo_mask  = (MAX_X'(1) << expo_bits(x)) - MAX_X'(1);
        expo_field = (word >> mant_bits(x)) & expo_mask;
        return (expo_field == expo_mask) && ((word & mant_mask) != '0);
    endfunction

endpackage

// File: rtl/fpu_result_buffer_if.sv
// Producer/consumer handshake bundle for the multiplier result buffer.
interface fpu_result_buffer_if #(
    parameter int unsigned X = 32
);
    logic         in_valid;
    logic [X-1:0] in_data;
    logic         in_ovf;
    logic         in_unf;
    logic         in_ready;
    logic         out_valid;
    logic [X-1:0] out_data;
    logic         out_ovf;
    logic         out_unf;
    logic         out_ready;

    modport master (
        output in_valid, in_data, in_ovf, in_unf, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_data, in_ovf, in_unf, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_unf
    );
endinterface

// File: rtl/fpu_result_buffer.sv
// In-order FIFO for multiplier results with sticky overflow/underflow/NaN flags.
// Ready/valid are decoded from the registered count only; no fall-through or bypass.
module fpu_result_buffer
    import fpu_pkg::*;
#(
    parameter int unsigned X     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    fpu_result_buffer_if.slave      bus,
    input  logic                    flag_clr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    sticky_ovf,
    output logic                    sticky_unf,
    output logic                    sticky_nan
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [X-1:0]  mem_data [DEPTH];
    logic          mem_ovf  [DEPTH];
    logic          mem_unf  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          ready;
    logic          valid;
    logic          push;
    logic          pop;
    logic          in_nan;

    assign ready  = (count != CW'(DEPTH));
    assign valid  = (count != '0);
    assign push   = bus.in_valid & ready;
    assign pop    = valid & bus.out_ready;
    assign in_nan = is_nan(MAX_X'(bus.in_data), X);

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? mem_data[rd_ptr] : '0;
    assign bus.out_ovf   = valid ? mem_ovf[rd_ptr]  : 1'b0;
    assign bus.out_unf   = valid ? mem_unf[rd_ptr]  : 1'b0;

    // Storage carries no reset; pointers/count define what is live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_data[wr_ptr] <= bus.in_data;
            mem_ovf[wr_ptr]  <= bus.in_ovf;
            mem_unf[wr_ptr]  <= bus.in_unf;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A setting push on the clear edge wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
            sticky_nan <= 1'b0;
        end else begin
            sticky_ovf <= (sticky_ovf & ~flag_clr) | (push & bus.in_ovf);
            sticky_unf <= (sticky_unf & ~flag_clr) | (push & bus.in_unf);
            sticky_nan <= (sticky_nan & ~flag_clr) | (push & in_nan);
        end
    end

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Bench for fpu_result_buffer: directed scenarios plus random traffic against a queue model.
module tb_fpu_result_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
        logic        unf;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flag_clr;
    logic [CW-1:0] count;
    logic          sticky_ovf, sticky_unf, sticky_nan;
    logic          flag_clr64;
    logic [CW-1:0] count64;
    logic          sticky_ovf64, sticky_unf64, sticky_nan64;

    fpu_result_buffer_if #(.X(32)) bus ();
    fpu_result_buffer_if #(.X(64)) bus64 ();

    fpu_result_buffer #(.X(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus), .flag_clr(flag_clr), .count(count),
        .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf), .sticky_nan(sticky_nan)
    );

    fpu_result_buffer #(.X(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .rst(rst), .bus(bus64), .flag_clr(flag_clr64), .count(count64),
        .sticky_ovf(sticky_ovf64), .sticky_unf(sticky_unf64), .sticky_nan(sticky_nan64)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t mq[$];
    logic m_sovf, m_sunf, m_snan;

    function automatic logic nan32(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    endfunction

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_ovf    = 1'b0;
        bus.in_unf    = 1'b0;
        bus.out_ready = 1'b0;
        flag_clr      = 1'b0;
    endtask

    // Advance one edge; the model applies the push/pop rules to the values presented.
    task automatic cycle();
        bit   do_push, do_pop, clr, r;
        ent_t e;
        do_push = bus.in_valid && (mq.size() < DEPTH);
        do_pop  = bus.out_ready && (mq.size() > 0);
        e.data  = bus.in_data;
        e.ovf   = bus.in_ovf;
        e.unf   = bus.in_unf;
        clr     = flag_clr;
        r       = rst;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_sovf = 1'b0; m_sunf = 1'b0; m_snan = 1'b0;
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
            m_sovf = (m_sovf && !clr) || (do_push && e.ovf);
            m_sunf = (m_sunf && !clr) || (do_push && e.unf);
            m_snan = (m_snan && !clr) || (do_push && nan32(e.data));
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d, input logic o, input logic u);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_ovf = o; bus.in_unf = u;
        cycle();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ovf = 1'b0; bus.in_unf = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        repeat (DEPTH + 1) cycle();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++;
        if (count !== CW'(0)) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_hs got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        n_checks++;
        if ({bus.out_data, bus.out_ovf, bus.out_unf} !== 34'd0) begin
            n_fail++; $display("FAIL reset_out got %h/%b/%b want 0", bus.out_data, bus.out_ovf, bus.out_unf);
        end
        n_checks++;
        if ({sticky_ovf, sticky_unf, sticky_nan} !== 3'b000) begin
            n_fail++; $display("FAIL reset_sticky got %b%b%b want 000", sticky_ovf, sticky_unf, sticky_nan);
        end
    endtask

    task automatic test_single_push();
        bus.in_valid = 1'b1; bus.in_data = 32'h3FC00000;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_nofallthru got %b want 0", bus.out_valid); end
        cycle();
        idle();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3FC00000 || count !== CW'(1)) begin
            n_fail++; $display("FAIL single_push got v=%b d=%h c=%0d want 1/3fc00000/1", bus.out_valid, bus.out_data, count);
        end
        drain();
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 5; i++) push(32'(i), 1'b0, 1'b0);
        n_checks++;
        if (bus.in_ready !== 1'b0 || count !== CW'(4)) begin
            n_fail++; $display("FAIL fill_full got ready=%b count=%0d want 0/4", bus.in_ready, count);
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(k)) begin
                n_fail++; $display("FAIL drain_order got v=%b d=%h want 1/%h", bus.out_valid, bus.out_data, 32'(k));
            end
            cycle();
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || count !== CW'(0)) begin
            n_fail++; $display("FAIL drain_empty got v=%b d=%h c=%0d want 0/0/0", bus.out_valid, bus.out_data, count);
        end
    endtask

    task automatic test_back_to_back();
        push(32'hA0, 1'b0, 1'b0);
        push(32'hA1, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 32'hA2 + 32'(i);
            n_checks++;
            if (count !== CW'(2) || bus.out_data !== 32'hA0 + 32'(i)) begin
                n_fail++; $display("FAIL b2b_step%0d got c=%0d d=%h want 2/%h", i, count, bus.out_data, 32'hA0 + 32'(i));
            end
            cycle();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (bus.out_data !== 32'hA8 + 32'(i)) begin
                n_fail++; $display("FAIL b2b_tail got %h want %h", bus.out_data, 32'hA8 + 32'(i));
            end
            cycle();
        end
        idle();
    endtask

    task automatic test_sticky();
        push(32'h7F800000, 1'b1, 1'b0);
        push(32'h7FC00000, 1'b0, 1'b0);
        n_checks++;
        if ({sticky_ovf, sticky_unf, sticky_nan} !== 3'b101) begin
            n_fail++; $display("FAIL sticky_set got %b%b%b want 101", sticky_ovf, sticky_unf, sticky_nan);
        end
        n_checks++;
        if (bus.out_ovf !== 1'b1 || bus.out_unf !== 1'b0) begin
            n_fail++; $display("FAIL head_flags got %b%b want 10", bus.out_ovf, bus.out_unf);
        end
        flag_clr = 1'b1;
        push(32'h00000000, 1'b0, 1'b1);
        flag_clr = 1'b0;
        n_checks++;
        if ({sticky_ovf, sticky_unf, sticky_nan} !== 3'b010) begin
            n_fail++; $display("FAIL sticky_clr_set got %b%b%b want 010", sticky_ovf, sticky_unf, sticky_nan);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        push(32'h11, 1'b1, 1'b0);
        push(32'h12, 1'b0, 1'b1);
        push(32'h7FC00001, 1'b0, 1'b0);
        n_checks++;
        if (count !== CW'(3)) begin n_fail++; $display("FAIL mid_fill got %0d want 3", count); end
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'h55; bus.out_ready = 1'b1;
        cycle();
        rst = 1'b0;
        idle();
        n_checks++;
        if (count !== CW'(0) || bus.out_valid !== 1'b0 || {sticky_ovf, sticky_unf, sticky_nan} !== 3'b000) begin
            n_fail++; $display("FAIL mid_reset got c=%0d v=%b s=%b%b%b want 0/0/000", count, bus.out_valid,
                               sticky_ovf, sticky_unf, sticky_nan);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] exp_d;
        for (int t = 0; t < 400; t++) begin
            exp_d = (mq.size() > 0) ? mq[0].data : 32'd0;
            n_checks++;
            if (count !== CW'(mq.size()) || bus.out_valid !== (mq.size() > 0) ||
                bus.in_ready !== (mq.size() < DEPTH) || bus.out_data !== exp_d) begin
                n_fail++; $display("FAIL rand_q t=%0d got c=%0d v=%b r=%b d=%h want c=%0d d=%h", t, count,
                                   bus.out_valid, bus.in_ready, bus.out_data, mq.size(), exp_d);
            end
            n_checks++;
            if (mq.size() > 0 && (bus.out_ovf !== mq[0].ovf || bus.out_unf !== mq[0].unf)) begin
                n_fail++; $display("FAIL rand_flags t=%0d got %b%b want %b%b", t, bus.out_ovf, bus.out_unf,
                                   mq[0].ovf, mq[0].unf);
            end
            n_checks++;
            if ({sticky_ovf, sticky_unf, sticky_nan} !== {m_sovf, m_sunf, m_snan}) begin
                n_fail++; $display("FAIL rand_sticky t=%0d got %b%b%b want %b%b%b", t, sticky_ovf, sticky_unf,
                                   sticky_nan, m_sovf, m_sunf, m_snan);
            end
            d = $urandom;
            if ($urandom_range(3) == 0) d[30:23] = 8'hFF;
            if ($urandom_range(7) == 0) d[22:0] = 23'd0;
            bus.in_valid  = ($urandom_range(2) != 0);
            bus.in_data   = d;
            bus.in_ovf    = ($urandom_range(7) == 0);
            bus.in_unf    = ($urandom_range(7) == 0);
            bus.out_ready = ($urandom_range(2) == 0);
            flag_clr      = ($urandom_range(15) == 0);
            cycle();
        end
        idle();
        drain();
    endtask

    task automatic test_x64();
        bus64.in_valid = 1'b1; bus64.in_data = 64'h7FF0000000000001;
        cycle();
        bus64.in_valid = 1'b0; bus64.in_data = '0;
        n_checks++;
        if (sticky_nan64 !== 1'b1 || bus64.out_data !== 64'h7FF0000000000001 || count64 !== CW'(1)) begin
            n_fail++; $display("FAIL x64_nan got n=%b d=%h c=%0d want 1/7ff0000000000001/1", sticky_nan64,
                               bus64.out_data, count64);
        end
        flag_clr64 = 1'b1; bus64.out_ready = 1'b1;
        cycle();
        flag_clr64 = 1'b0; bus64.out_ready = 1'b0;
        bus64.in_valid = 1'b1; bus64.in_data = 64'h7FF0000000000000;
        cycle();
        bus64.in_valid = 1'b0;
        n_checks++;
        if (sticky_nan64 !== 1'b0 || bus64.out_data !== 64'h7FF0000000000000) begin
            n_fail++; $display("FAIL x64_inf got n=%b d=%h want 0/7ff0000000000000", sticky_nan64, bus64.out_data);
        end
    endtask

    initial begin
        rst = 1'b0;
        m_sovf = 1'b0; m_sunf = 1'b0; m_snan = 1'b0;
        idle();
        bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_ovf = 1'b0;
        bus64.in_unf = 1'b0; bus64.out_ready = 1'b0; flag_clr64 = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_push();
        test_fill_drain();
        test_back_to_back();
        test_sticky();
        test_reset_mid();
        test_random();
        test_x64();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_result_buffer.md
FPU_RESULT_BUFFER -- requirements
Module: fpu_result_buffer

Interface
REQ-001 Parameter X, default 32, operand/result width; legal values 32 and 64 only.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, 2..16.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  multiplier result present this cycle.
REQ-006 in_data  input  X  multiplier result word {sign, exponent, mantissa}.
REQ-007 in_ovf  input  1  multiplier overflow flag for in_data.
REQ-008 in_unf  input  1  multiplier underflow flag for in_data.
REQ-009 in_ready  output  1  buffer can accept an entry this cycle.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_data  output  X  head entry result word.
REQ-012 out_ovf  output  1  head entry overflow flag.
REQ-013 out_unf  output  1  head entry underflow flag.
REQ-014 out_ready  input  1  consumer takes head entry this cycle.
REQ-015 count  output  clog2(DEPTH)+1  number of stored entries.
REQ-016 sticky_ovf  output  1  overflow seen on any accepted entry since last clear.
REQ-017 sticky_unf  output  1  underflow seen on any accepted entry since last clear.
REQ-018 sticky_nan  output  1  NaN (exponent all ones, mantissa nonzero) seen on any accepted entry since last clear.
REQ-019 flag_clr  input  1  clears all sticky flags.

Function
REQ-020 Push occurs on a rising edge where in_valid and in_ready are both 1; pop occurs where out_valid and out_ready are both 1.
REQ-021 in_ready SHALL equal (count != DEPTH), combinational from registered state only; no same-cycle pop-to-push bypass when full.
REQ-022 out_valid SHALL equal (count != 0); no fall-through: a pushed entry appears on the outputs the cycle after the push edge (latency 1).
REQ-023 out_data, out_ovf, out_unf SHALL show the oldest entry when out_valid=1 and SHALL be all zero when out_valid=0.
REQ-024 Entries SHALL leave in strict push order; each entry stores {in_data, in_ovf, in_unf} unmodified.
REQ-025 Simultaneous push and pop with 0<count<DEPTH: both occur, count unchanged.
REQ-026 Push while full is ignored (in_ready=0); pop while empty is ignored (out_valid=0); count never exceeds DEPTH or underflows.
REQ-027 Read and write pointers are clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-028 Exponent field for NaN detect: bits [X-2:X-12] when X=64, [X-2:X-9] when X=32; mantissa is the remaining low bits.
REQ-029 Sticky flags SHALL set on the edge of a push whose entry carries the condition; they hold until flag_clr.
REQ-030 flag_clr and a flag-setting push on the same edge: the flag SHALL be 1 afterwards (set wins).
REQ-031 No combinational path from in_valid/in_data to any output; out_ready affects no output combinationally.

Reset
REQ-032 On rst=1 at a rising edge: count=0, pointers=0, in_ready=1, out_valid=0, out_data/out_ovf/out_unf=0, all sticky flags=0.
REQ-033 rst mid-operation discards all stored entries; a push or pop on the reset edge SHALL have no effect.
REQ-034 Storage array contents need not be reset.

Structure
REQ-035 Shared package fpu_pkg holds expo_bits, mant_bits and bias as functions of X (8/23/127 for 32; 11/52/1023 for 64), plus the NaN-detect function.
REQ-036 No sub-module; storage, pointers and sticky logic live in fpu_result_buffer.

Verification
REQ-037 X=32, push 32'h3FC00000 (ovf=0,unf=0) with out_ready=0 -> next cycle out_valid=1, out_data=32'h3FC00000, count=1.
REQ-038 Push 5 entries 32'h00000001..32'h00000005 with out_ready=0 -> in_ready=0 after 4th, count=4, 5th dropped; then drain -> outputs 1,2,3,4 in order, then out_valid=0, out_data=0.
REQ-039 count=2, in_valid=1 and out_ready=1 for 8 cycles -> count stays 2, order preserved across pointer wrap.
REQ-040 Push 32'h7F800000 with ovf=1, then 32'h7FC00000 -> sticky_ovf=1, sticky_nan=1, sticky_unf=0; flag_clr with simultaneous push of 32'h00000000 unf=1 -> sticky_unf=1, sticky_ovf=0, sticky_nan=0.
REQ-041 Fill to count=3, assert rst for one cycle with in_valid=1 -> count=0, out_valid=0, all sticky flags 0.
REQ-042 X=64, push 64'h7FF0000000000001 -> sticky_nan=1, out_data=64'h7FF0000000000001.
